// File: rtl/req_ack_fifo.sv
// Synchronous FIFO answering req/ack initiators on both ports.
// Each port runs four-phase handshake or streaming mode; stream pop is first-word fall-through.
module req_ack_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [WIDTH-1:0]  push_data_in,
    input  logic              push_stream_mode,
    output logic              push_ack,
    output logic              push_ack_pulse,
    output logic              fifo_full,
    input  logic              pop_req,
    input  logic              pop_stream_mode,
    output logic [WIDTH-1:0]  pop_data_out,
    output logic              pop_ack,
    output logic              pop_ack_pulse,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {PIDLE, PACK} push_state_t;
    typedef enum logic {QIDLE, QACK} pop_state_t;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [WIDTH-1:0]  pop_data_q;
    push_state_t       push_state;
    push_state_t       push_next;
    pop_state_t        pop_state;
    pop_state_t        pop_next;
    logic              write_c;
    logic              read_c;

    assign fifo_full  = (count == CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);

    // Push port: stream mode never leaves PIDLE, so ack is the live qualifier
    always_comb begin
        push_next = push_state;
        write_c   = 1'b0;
        push_ack  = 1'b0;
        case (push_state)
            PIDLE: begin
                if (push_req && !fifo_full) begin
                    write_c = 1'b1;
                    if (push_stream_mode) begin
                        push_ack = 1'b1;
                    end else begin
                        push_next = PACK;
                    end
                end
            end
            PACK: begin
                push_ack = 1'b1;
                if (!push_req) begin
                    push_next = PIDLE;
                end
            end
            default: push_next = PIDLE;
        endcase
    end

    // Pop port: stream mode shows mem[rptr] directly, handshake shows the captured word
    always_comb begin
        pop_next     = pop_state;
        read_c       = 1'b0;
        pop_ack      = 1'b0;
        pop_data_out = pop_data_q;
        case (pop_state)
            QIDLE: begin
                if (pop_stream_mode) begin
                    pop_data_out = mem[rptr];
                end
                if (pop_req && !fifo_empty) begin
                    read_c = 1'b1;
                    if (pop_stream_mode) begin
                        pop_ack = 1'b1;
                    end else begin
                        pop_next = QACK;
                    end
                end
            end
            QACK: begin
                pop_ack = 1'b1;
                if (!pop_req) begin
                    pop_next = QIDLE;
                end
            end
            default: pop_next = QIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_state     <= PIDLE;
            pop_state      <= QIDLE;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            pop_data_q     <= '0;
            push_ack_pulse <= 1'b0;
            pop_ack_pulse  <= 1'b0;
        end else begin
            push_state     <= push_next;
            pop_state      <= pop_next;
            push_ack_pulse <= write_c;
            pop_ack_pulse  <= read_c;
            count          <= count + CNT_W'(write_c) - CNT_W'(read_c);
            if (write_c) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (read_c) begin
                rptr       <= rptr + ADDR_W'(1);
                pop_data_q <= mem[rptr];
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (write_c) begin
            mem[wptr] <= push_data_in;
        end
    end

endmodule
